// File: rtl/nibble_sub_seq_pkg.sv
// -----------------------------------------------------------------------------
// nibble_sub_seq_pkg
// Shared constants for the nibble-serial subtract sequencer:
//   - NIBBLE_W        width of the shared add slice
//   - DEFAULT_NIBBLES default operand width in nibbles
//   - ST_*            2-bit controller state encodings
// -----------------------------------------------------------------------------
package nibble_sub_seq_pkg;

  localparam int NIBBLE_W        = 4;
  localparam int DEFAULT_NIBBLES = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SUB  = 2'd1;
  localparam logic [1:0] ST_NEG  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

endpackage

// File: rtl/nibble_add4.sv
// -----------------------------------------------------------------------------
// nibble_add4
// Combinational 4-bit ripple adder: {cout, s} = a + b + cin.
// Ports:
//   s    out 4  sum
//   cout out 1  carry out of bit 3
//   a    in  4  operand
//   b    in  4  operand
//   cin  in  1  carry in to bit 0
// -----------------------------------------------------------------------------
module nibble_add4
  import nibble_sub_seq_pkg::*;
(
  output logic [NIBBLE_W-1:0] s,
  output logic                cout,
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin
);

  logic [NIBBLE_W:0] w_c;

  assign w_c[0] = cin;

  for (genvar gi = 0; gi < NIBBLE_W; gi++) begin : g_fa
    assign s[gi]      = a[gi] ^ b[gi] ^ w_c[gi];
    assign w_c[gi+1]  = (a[gi] & b[gi]) | (a[gi] & w_c[gi]) | (b[gi] & w_c[gi]);
  end

  assign cout = w_c[NIBBLE_W];

endmodule

// File: rtl/nibble_sub_seq.sv
// -----------------------------------------------------------------------------
// nibble_sub_seq
// Multi-precision unsigned subtractor built around a single 4-bit add slice.
// a-b is formed one nibble per cycle, LSB first, as a + ~b + carry. With mag
// set and a borrow out of the top nibble, a second pass two's-complements the
// working register (~work + 1) through the same slice, giving |a-b|.
// Ports:
//   clk   in  1  clock, rising edge
//   rst   in  1  synchronous active-high reset
//   start in  1  request, accepted in IDLE or DONE
//   mag   in  1  1 = return |a-b|, 0 = raw two's-complement difference
//   a     in  W  minuend (captured on accept)
//   b     in  W  subtrahend (captured on accept)
//   busy  out 1  high while subtracting or negating
//   done  out 1  one-cycle result-valid pulse
//   diff  out W  result, held until the next done
//   neg   out 1  borrow out of the MSB nibble (a < b), held with diff
// -----------------------------------------------------------------------------
module nibble_sub_seq
  import nibble_sub_seq_pkg::*;
#(
  parameter int NIBBLES = DEFAULT_NIBBLES
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         mag,
  input  logic [NIBBLE_W*NIBBLES-1:0]  a,
  input  logic [NIBBLE_W*NIBBLES-1:0]  b,
  output logic                         busy,
  output logic                         done,
  output logic [NIBBLE_W*NIBBLES-1:0]  diff,
  output logic                         neg
);

  localparam int W  = NIBBLE_W * NIBBLES;
  localparam int IW = $clog2(NIBBLES);
  localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

  logic [1:0]          r_state;
  logic [IW-1:0]       r_idx;
  logic                r_carry;
  logic                r_mag;
  logic [W-1:0]        r_a;
  logic [W-1:0]        r_b;
  logic [W-1:0]        r_work;
  logic [W-1:0]        r_diff;
  logic                r_neg;

  logic [NIBBLE_W-1:0] w_a_arr    [NIBBLES];
  logic [NIBBLE_W-1:0] w_b_arr    [NIBBLES];
  logic [NIBBLE_W-1:0] w_work_arr [NIBBLES];
  logic [NIBBLE_W-1:0] w_op_a;
  logic [NIBBLE_W-1:0] w_op_b;
  logic [NIBBLE_W-1:0] w_sum;
  logic                w_cout;
  logic [W-1:0]        w_work_upd;
  logic                w_last;

  // Nibble views of the operands, plus the working register with the current
  // nibble replaced by this cycle's sum (so the final nibble is visible in the
  // same edge that publishes diff).
  for (genvar gi = 0; gi < NIBBLES; gi++) begin : g_nib
    assign w_a_arr[gi]    = r_a[gi*NIBBLE_W +: NIBBLE_W];
    assign w_b_arr[gi]    = r_b[gi*NIBBLE_W +: NIBBLE_W];
    assign w_work_arr[gi] = r_work[gi*NIBBLE_W +: NIBBLE_W];
    assign w_work_upd[gi*NIBBLE_W +: NIBBLE_W] =
      (r_idx == IW'(gi)) ? w_sum : r_work[gi*NIBBLE_W +: NIBBLE_W];
  end

  // SUB: a + ~b + c.  NEG: ~work + 0 + c (carry seeded with 1 = +1).
  assign w_op_a = (r_state == ST_NEG) ? ~w_work_arr[r_idx] : w_a_arr[r_idx];
  assign w_op_b = (r_state == ST_NEG) ? '0 : ~w_b_arr[r_idx];
  assign w_last = (r_idx == LAST_IDX);

  nibble_add4 u_add (
    .s    (w_sum),
    .cout (w_cout),
    .a    (w_op_a),
    .b    (w_op_b),
    .cin  (r_carry)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_mag   <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_work  <= '0;
      r_diff  <= '0;
      r_neg   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_mag   <= mag;
            r_idx   <= '0;
            r_carry <= 1'b1;
            r_state <= ST_SUB;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_SUB: begin
          r_work  <= w_work_upd;
          r_carry <= w_cout;
          r_idx   <= r_idx + 1'b1;
          if (w_last) begin
            // No carry out of the top nibble means a borrow: a < b.
            if (r_mag && !w_cout) begin
              r_idx   <= '0;
              r_carry <= 1'b1;
              r_state <= ST_NEG;
            end else begin
              r_idx   <= '0;
              r_diff  <= w_work_upd;
              r_neg   <= ~w_cout;
              r_state <= ST_DONE;
            end
          end
        end
        ST_NEG: begin
          r_work  <= w_work_upd;
          r_carry <= w_cout;
          r_idx   <= r_idx + 1'b1;
          if (w_last) begin
            r_idx   <= '0;
            r_diff  <= w_work_upd;
            r_neg   <= 1'b1;
            r_state <= ST_DONE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy = (r_state == ST_SUB) || (r_state == ST_NEG);
  assign done = (r_state == ST_DONE);
  assign diff = r_diff;
  assign neg  = r_neg;

endmodule

// File: tb/tb_nibble_sub_seq.sv
// -----------------------------------------------------------------------------
// tb_nibble_sub_seq
// Scoreboard bench for nibble_sub_seq. Two instances: NIBBLES=4 (id 0) and
// NIBBLES=2 (id 1). Each accepted request pushes its hand-computed result and
// expected latency; a monitor pops and compares on every done pulse. Latency
// is counted with the start cycle as cycle 0, so done lands in cycle N+1
// (2N+1 with a negate pass).
// -----------------------------------------------------------------------------
module tb_nibble_sub_seq;

  typedef struct {
    int          id;
    logic [15:0] diff;
    logic        neg;
    int          lat;
    int          t0;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start4 = 1'b0, mag4 = 1'b0;
  logic [15:0] a4 = '0, b4 = '0;
  logic        busy4, done4, neg4;
  logic [15:0] diff4;
  logic        start2 = 1'b0, mag2 = 1'b0;
  logic [7:0]  a2 = '0, b2 = '0;
  logic        busy2, done2, neg2;
  logic [7:0]  diff2;

  exp_t sb_q[$];
  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  nibble_sub_seq #(.NIBBLES(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .mag(mag4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .diff(diff4), .neg(neg4)
  );

  nibble_sub_seq #(.NIBBLES(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .mag(mag2), .a(a2), .b(b2),
    .busy(busy2), .done(done2), .diff(diff2), .neg(neg2)
  );

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic on_done(int id, logic [15:0] d, logic n);
    exp_t e;
    if (sb_q.size() == 0) begin
      n_total++;
      $display("FAIL unexpected_done: dut %0d diff %0h neg %0b, nothing expected", id, d, n);
      return;
    end
    e = sb_q.pop_front();
    chk("dut_id", id, e.id);
    chk("diff", {16'h0, d}, {16'h0, e.diff});
    chk("neg", {31'h0, n}, {31'h0, e.neg});
    chk("latency", cyc - e.t0 + 1, e.lat);
    $display("txn dut%0d diff=%h neg=%0b lat=%0d (exp %h/%0b/%0d)",
             id, d, n, cyc - e.t0 + 1, e.diff, e.neg, e.lat);
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (done4) on_done(0, diff4, neg4);
      if (done2) on_done(1, {8'h0, diff2}, neg2);
    end
  end

  task automatic push(int id, logic [15:0] ed, logic en, int lat);
    exp_t e;
    e.id = id; e.diff = ed; e.neg = en; e.lat = lat; e.t0 = cyc;
    sb_q.push_back(e);
  endtask

  task automatic drive(int id, logic [15:0] av, logic [15:0] bv, logic m);
    if (id == 0) begin a4 = av; b4 = bv; mag4 = m; start4 = 1'b1; end
    else begin a2 = av[7:0]; b2 = bv[7:0]; mag2 = m; start2 = 1'b1; end
  endtask

  task automatic issue(int id, logic [15:0] av, logic [15:0] bv, logic m,
                       logic [15:0] ed, logic en, int lat);
    @(negedge clk);
    drive(id, av, bv, m);
    @(posedge clk); #1;
    push(id, ed, en, lat);
    @(negedge clk);
    start4 = 1'b0; start2 = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && sb_q.size() != 0; i++) @(posedge clk);
    chk("drain_pending", sb_q.size(), 0);
    sb_q.delete();
    repeat (4) @(posedge clk);
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", {31'h0, busy4}, 0);
    chk("rst_done", {31'h0, done4}, 0);
    chk("rst_diff", {16'h0, diff4}, 0);
    chk("rst_neg",  {31'h0, neg4}, 0);
    rst = 1'b0;

    // Directed vectors, NIBBLES=4
    issue(0, 16'h1234, 16'h0034, 1'b0, 16'h1200, 1'b0, 5);  drain();
    issue(0, 16'h0000, 16'hFFFF, 1'b0, 16'h0001, 1'b1, 5);  drain();
    issue(0, 16'h0000, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 9);  drain();
    issue(0, 16'hABCD, 16'hABCD, 1'b1, 16'h0000, 1'b0, 5);  drain();
    issue(0, 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b0, 5);  drain();
    issue(0, 16'h0001, 16'h8000, 1'b1, 16'h7FFF, 1'b1, 9);  drain();
    issue(0, 16'hFFFF, 16'h0000, 1'b0, 16'hFFFF, 1'b0, 5);  drain();
    issue(0, 16'h0005, 16'h0007, 1'b0, 16'hFFFE, 1'b1, 5);  drain();

    // Start while busy (cycle 2) with new operands: ignored
    issue(0, 16'h1234, 16'h0034, 1'b0, 16'h1200, 1'b0, 5);
    @(negedge clk);                       // cycle 2
    drive(0, 16'hFFFF, 16'h0001, 1'b1);
    @(negedge clk);
    start4 = 1'b0;
    drain();

    // Start held through done: second request accepted in the DONE cycle
    @(negedge clk);
    drive(0, 16'h1234, 16'h0034, 1'b0);
    @(posedge clk); #1;
    push(0, 16'h1200, 1'b0, 5);
    @(negedge clk);
    drive(0, 16'h0005, 16'h0007, 1'b1);   // start stays high while busy
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
        @(negedge clk);
        if (done4) seen = 1'b1;
      end
      chk("b2b_first_done_seen", {31'h0, seen}, 1);
    end
    @(posedge clk); #1;
    push(0, 16'h0002, 1'b1, 9);
    @(negedge clk);
    start4 = 1'b0;
    drain();

    // Reset in cycle 3 of a negate run: abort, no done
    @(negedge clk);
    drive(0, 16'h0000, 16'hFFFF, 1'b1);
    @(posedge clk);                       // accept, cycle 1
    @(negedge clk);
    start4 = 1'b0;
    @(posedge clk);                       // cycle 2
    @(posedge clk);                       // cycle 3
    @(negedge clk);
    chk("pre_rst_busy", {31'h0, busy4}, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_busy", {31'h0, busy4}, 0);
    chk("abort_done", {31'h0, done4}, 0);
    chk("abort_diff", {16'h0, diff4}, 0);
    chk("abort_neg",  {31'h0, neg4}, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (15) @(posedge clk);           // monitor flags any stray done

    // NIBBLES=2 instance
    issue(1, 16'h0034, 16'h0012, 1'b0, 16'h0022, 1'b0, 3);  drain();
    issue(1, 16'h0000, 16'h00FF, 1'b0, 16'h0001, 1'b1, 3);  drain();
    issue(1, 16'h0000, 16'h00FF, 1'b1, 16'h00FF, 1'b1, 5);  drain();
    issue(1, 16'h00CD, 16'h00CD, 1'b1, 16'h0000, 1'b0, 3);  drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
